// File: rtl/irrig_pkg.sv
// Shared types for the multi-zone irrigation controller: FSM state codes,
// tank level codes and run mode.
package irrig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_IRRIGATE = 3'd2,
    ST_REST     = 3'd3,
    ST_FAULT    = 3'd4
  } estado_t;

  typedef enum logic [1:0] {
    TANK_EMPTY = 2'd0,
    TANK_LOW   = 2'd1,
    TANK_MID   = 2'd2,
    TANK_FULL  = 2'd3
  } nivel_t;

  typedef enum logic {
    MODE_DRIP     = 1'b0,
    MODE_SPRINKLE = 1'b1
  } modo_t;

endpackage

// File: rtl/nivel_tanque_fsm.sv
// Tank level decoder with sensor-fault detection and the inlet-valve (Ve)
// hysteresis register.
module nivel_tanque_fsm
  import irrig_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic nivel_h,
  input  logic nivel_m,
  input  logic nivel_l,
  input  logic inibe,
  output logic falha,
  output logic vazio,
  output logic Ve
);

  nivel_t nivel;

  always_comb begin
    falha = 1'b0;
    nivel = TANK_EMPTY;
    case ({nivel_h, nivel_m, nivel_l})
      3'b000:  nivel = TANK_EMPTY;
      3'b001:  nivel = TANK_LOW;
      3'b011:  nivel = TANK_MID;
      3'b111:  nivel = TANK_FULL;
      default: falha = 1'b1;
    endcase
  end

  assign vazio = !falha && (nivel == TANK_EMPTY);

  // MID holds the previous valve state, giving fill hysteresis between LOW and FULL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Ve <= 1'b0;
    end else if (falha || inibe) begin
      Ve <= 1'b0;
    end else begin
      case (nivel)
        TANK_EMPTY, TANK_LOW: Ve <= 1'b1;
        TANK_FULL:            Ve <= 1'b0;
        default:              Ve <= Ve;
      endcase
    end
  end

endmodule

// File: rtl/irrigacao_multizona.sv
// Round-robin multi-zone irrigation controller with tank interlock and fault alarm.
// Define BCD_TIME_EN to add mm:ss BCD outputs (seg_u, seg_d, min_u, min_d) of restante.
module irrigacao_multizona
  import irrig_pkg::*;
#(
  parameter int N_ZONES    = 4,
  parameter int TIME_W     = 12,
  parameter int DRIP_S     = 300,
  parameter int SPRINKLE_S = 120,
  parameter int REST_S     = 10,
  localparam int ZW        = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick_1s,
  input  logic               habilita,
  input  logic               nivel_h,
  input  logic               nivel_m,
  input  logic               nivel_l,
  input  logic               ar_seco,
  input  logic               temp_alta,
  input  logic [N_ZONES-1:0] solo_seco,
  output logic               Ve,
  output logic               Vs,
  output logic               Bs,
  output logic [N_ZONES-1:0] zona_ativa,
  output logic [ZW-1:0]      zona_idx,
  output logic [TIME_W-1:0]  restante,
  output logic [2:0]         estado,
  output logic               Erro,
  output logic               Alarme
`ifdef BCD_TIME_EN
  ,
  output logic [3:0]         seg_u,
  output logic [3:0]         seg_d,
  output logic [3:0]         min_u,
  output logic [3:0]         min_d
`endif
);

  localparam int SW = N_ZONES + 5;

  logic [SW-1:0] sync1, sync2;
  logic          h_s, m_s, l_s, ar_s, temp_s;
  logic [N_ZONES-1:0] solo_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {solo_seco, temp_alta, ar_seco, nivel_l, nivel_m, nivel_h};
      sync2 <= sync1;
    end
  end

  assign {solo_s, temp_s, ar_s, l_s, m_s, h_s} = sync2;

  estado_t               st;
  logic                  falha, vazio;
  logic [ZW-1:0]         ptr, scan_idx, scan_cnt, zona_q;
  logic [TIME_W-1:0]     timer;
  logic                  vs_q, bs_q, erro_q;
  logic [N_ZONES-1:0]    zona_ativa_q;
  logic                  solo_scan, solo_zona;
  modo_t                 modo_novo;

  nivel_tanque_fsm u_tanque (
    .clk     (clk),
    .reset_n (reset_n),
    .nivel_h (h_s),
    .nivel_m (m_s),
    .nivel_l (l_s),
    .inibe   (st == ST_FAULT),
    .falha   (falha),
    .vazio   (vazio),
    .Ve      (Ve)
  );

  function automatic logic [ZW-1:0] next_idx(input logic [ZW-1:0] i);
    next_idx = (i == ZW'(N_ZONES - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [N_ZONES-1:0] one_hot(input logic [ZW-1:0] i);
    one_hot = '0;
    for (int unsigned k = 0; k < N_ZONES; k++)
      if (i == ZW'(k)) one_hot[k] = 1'b1;
  endfunction

  always_comb begin
    solo_scan = 1'b0;
    solo_zona = 1'b0;
    for (int unsigned k = 0; k < N_ZONES; k++) begin
      if (scan_idx == ZW'(k)) solo_scan = solo_s[k];
      if (zona_q == ZW'(k))   solo_zona = solo_s[k];
    end
    modo_novo = (ar_s && !temp_s) ? MODE_SPRINKLE : MODE_DRIP;
  end

  // Priority: sensor fault, then scheduler disable, then normal sequencing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st           <= ST_IDLE;
      ptr          <= '0;
      scan_idx     <= '0;
      scan_cnt     <= '0;
      zona_q       <= '0;
      timer        <= '0;
      vs_q         <= 1'b0;
      bs_q         <= 1'b0;
      erro_q       <= 1'b0;
      zona_ativa_q <= '0;
    end else if (falha) begin
      st           <= ST_FAULT;
      timer        <= '0;
      vs_q         <= 1'b0;
      bs_q         <= 1'b0;
      erro_q       <= 1'b1;
      zona_ativa_q <= '0;
    end else if (st == ST_FAULT) begin
      if (tick_1s) begin
        st     <= ST_IDLE;
        erro_q <= 1'b0;
      end
    end else if (!habilita && st != ST_IDLE) begin
      st           <= ST_IDLE;
      timer        <= '0;
      vs_q         <= 1'b0;
      bs_q         <= 1'b0;
      zona_ativa_q <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (tick_1s && habilita) begin
            st       <= ST_SCAN;
            scan_idx <= ptr;
            scan_cnt <= '0;
          end
        end
        ST_SCAN: begin
          if (solo_scan && !vazio) begin
            st           <= ST_IRRIGATE;
            zona_q       <= scan_idx;
            zona_ativa_q <= one_hot(scan_idx);
            vs_q         <= (modo_novo == MODE_DRIP);
            bs_q         <= (modo_novo == MODE_SPRINKLE);
            timer        <= (modo_novo == MODE_SPRINKLE) ? TIME_W'(SPRINKLE_S) : TIME_W'(DRIP_S);
          end else if (scan_cnt == ZW'(N_ZONES - 1)) begin
            st <= ST_IDLE;
          end else begin
            scan_idx <= next_idx(scan_idx);
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        ST_IRRIGATE: begin
          if (!solo_zona || vazio || (tick_1s && timer <= TIME_W'(1))) begin
            st           <= ST_REST;
            timer        <= TIME_W'(REST_S);
            vs_q         <= 1'b0;
            bs_q         <= 1'b0;
            zona_ativa_q <= '0;
            ptr          <= next_idx(zona_q);
          end else if (tick_1s) begin
            timer <= timer - 1'b1;
          end
        end
        ST_REST: begin
          if (tick_1s) begin
            if (timer <= TIME_W'(1)) begin
              st       <= ST_SCAN;
              timer    <= '0;
              scan_idx <= ptr;
              scan_cnt <= '0;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign estado     = st;
  assign restante   = timer;
  assign zona_idx   = zona_q;
  assign zona_ativa = zona_ativa_q;
  assign Vs         = vs_q;
  assign Bs         = bs_q;
  assign Erro       = erro_q;
  assign Alarme     = erro_q | vazio;

`ifdef BCD_TIME_EN
  logic [TIME_W-1:0] mins, secs, mins_sat;

  always_comb begin
    mins     = timer / TIME_W'(60);
    secs     = timer % TIME_W'(60);
    mins_sat = (mins > TIME_W'(99)) ? TIME_W'(99) : mins;
    seg_u    = 4'(secs % TIME_W'(10));
    seg_d    = 4'(secs / TIME_W'(10));
    min_u    = 4'(mins_sat % TIME_W'(10));
    min_d    = 4'(mins_sat / TIME_W'(10));
  end
`endif

endmodule

// File: tb/tb_irrigacao_multizona.sv
// Self-checking bench for irrigacao_multizona: tank-decode vector table plus
// hand-written zone scheduling, fault and reset sequences.
module tb_irrigacao_multizona;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick_1s, habilita;
  logic       nivel_h, nivel_m, nivel_l, ar_seco, temp_alta;
  logic [3:0] solo_seco;
  logic       Ve, Vs, Bs, Erro, Alarme;
  logic [3:0] zona_ativa;
  logic [1:0] zona_idx;
  logic [11:0] restante;
  logic [2:0] estado;
`ifdef BCD_TIME_EN
  logic [3:0] seg_u, seg_d, min_u, min_d;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  irrigacao_multizona #(
    .N_ZONES(4), .TIME_W(12), .DRIP_S(300), .SPRINKLE_S(120), .REST_S(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick_1s(tick_1s), .habilita(habilita),
    .nivel_h(nivel_h), .nivel_m(nivel_m), .nivel_l(nivel_l),
    .ar_seco(ar_seco), .temp_alta(temp_alta), .solo_seco(solo_seco),
    .Ve(Ve), .Vs(Vs), .Bs(Bs), .zona_ativa(zona_ativa), .zona_idx(zona_idx),
    .restante(restante), .estado(estado), .Erro(Erro), .Alarme(Alarme)
`ifdef BCD_TIME_EN
    , .seg_u(seg_u), .seg_d(seg_d), .min_u(min_u), .min_d(min_d)
`endif
  );

  typedef struct {
    string       nome;
    int unsigned esperado;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0] hml;
    bit         tick;
    logic       ve, erro, alarme;
    logic [2:0] est;
  } tank_vec_t;
  tank_vec_t tv[13];

  function automatic int unsigned actual_of(string n);
    case (n)
      "estado":   return int'(estado);
      "restante": return int'(restante);
      "Vs":       return int'(Vs);
      "Bs":       return int'(Bs);
      "Ve":       return int'(Ve);
      "Erro":     return int'(Erro);
      "Alarme":   return int'(Alarme);
      "zona":     return int'(zona_ativa);
      "idx":      return int'(zona_idx);
`ifdef BCD_TIME_EN
      "seg_u":    return int'(seg_u);
      "seg_d":    return int'(seg_d);
      "min_u":    return int'(min_u);
      "min_d":    return int'(min_d);
`endif
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string n, input int unsigned v);
    sb_t e;
    e.nome = n;
    e.esperado = v;
    sb_q.push_back(e);
  endtask

  task automatic check_all(input string ctx);
    sb_t e;
    int unsigned a;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = actual_of(e.nome);
      checks++;
      if (a != e.esperado) begin
        errors++;
        $display("FAIL %s.%s: got %0d expected %0d", ctx, e.nome, a, e.esperado);
      end
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick_1s = 1'b1;
      @(negedge clk) tick_1s = 1'b0;
    end
  endtask

  task automatic set_tank(input logic [2:0] hml);
    {nivel_h, nivel_m, nivel_l} = hml;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tv[1]  = '{3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tv[2]  = '{3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tv[3]  = '{3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tv[4]  = '{3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0};
    tv[5]  = '{3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tv[6]  = '{3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tv[7]  = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4};
    tv[8]  = '{3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    tv[9]  = '{3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tv[10] = '{3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4};
    tv[11] = '{3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    tv[12] = '{3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

    reset_n = 1'b0; tick_1s = 1'b0; habilita = 1'b0;
    set_tank(3'b111); ar_seco = 1'b0; temp_alta = 1'b0; solo_seco = 4'b0000;
    clks(2);
    expect_val("estado", 0); expect_val("restante", 0); expect_val("Ve", 0);
    expect_val("Vs", 0); expect_val("Bs", 0); expect_val("zona", 0);
    expect_val("idx", 0); expect_val("Erro", 0);
    check_all("reset");
    reset_n = 1'b1;
    clks(3);

    // Tank decode / hysteresis / fault table, scheduler disabled
    for (int i = 0; i < 13; i++) begin
      set_tank(tv[i].hml);
      expect_val("Ve", tv[i].ve); expect_val("Erro", tv[i].erro);
      expect_val("Alarme", tv[i].alarme); expect_val("estado", tv[i].est);
      clks(4);
      if (tv[i].tick) tick_n(1);
      clks(2);
      check_all($sformatf("tank[%0d]", i));
    end

    // Drip run on zone 0 then zone 3; tick in load cycle must not decrement
    solo_seco = 4'b1001; ar_seco = 1'b0; temp_alta = 1'b0; habilita = 1'b1;
    clks(3);
    @(negedge clk) tick_1s = 1'b1;
    @(negedge clk);
    @(negedge clk) tick_1s = 1'b0;
    expect_val("estado", 2); expect_val("restante", 300); expect_val("Vs", 1);
    expect_val("Bs", 0); expect_val("zona", 4'b0001); expect_val("idx", 0);
`ifdef BCD_TIME_EN
    expect_val("min_u", 5); expect_val("min_d", 0); expect_val("seg_d", 0); expect_val("seg_u", 0);
`endif
    check_all("drip0_load");
    tick_n(299);
    expect_val("restante", 1); expect_val("estado", 2);
`ifdef BCD_TIME_EN
    expect_val("seg_u", 1); expect_val("min_u", 0);
`endif
    check_all("drip0_last");
    tick_n(1);
    expect_val("estado", 3); expect_val("restante", 10); expect_val("Vs", 0); expect_val("zona", 0);
    check_all("drip0_rest");
    tick_n(10);
    expect_val("estado", 1); expect_val("restante", 0);
    check_all("rest_to_scan");
    clks(3);
    expect_val("estado", 2); expect_val("zona", 4'b1000); expect_val("idx", 3);
    expect_val("Vs", 1); expect_val("restante", 300);
    check_all("drip3");
    solo_seco = 4'b0000;
    clks(3);
    expect_val("estado", 3); expect_val("restante", 10); expect_val("Vs", 0);
    check_all("soil_drop");
    tick_n(10);
    clks(5);
    expect_val("estado", 0); expect_val("idx", 3);
    check_all("scan_empty");
    solo_seco = 4'b1010;
    clks(3);
    tick_n(1);
    clks(2);
    expect_val("estado", 2); expect_val("idx", 1); expect_val("zona", 4'b0010);
    check_all("pointer_wrap");
    habilita = 1'b0;
    clks(1);
    expect_val("estado", 0); expect_val("Vs", 0); expect_val("zona", 0); expect_val("restante", 0);
    check_all("disable");

    // Sprinkler run on zone 2
    solo_seco = 4'b0100; ar_seco = 1'b1; temp_alta = 1'b0; habilita = 1'b1;
    clks(3);
    tick_n(1);
    clks(3);
    expect_val("estado", 2); expect_val("zona", 4'b0100); expect_val("Bs", 1);
    expect_val("Vs", 0); expect_val("restante", 120); expect_val("idx", 2);
`ifdef BCD_TIME_EN
    expect_val("min_u", 2); expect_val("seg_u", 0);
`endif
    check_all("sprk_start");
    tick_n(119);
    expect_val("restante", 1); expect_val("estado", 2); expect_val("Bs", 1);
    check_all("sprk_last");
    tick_n(1);
    expect_val("estado", 3); expect_val("restante", 10); expect_val("Bs", 0); expect_val("zona", 0);
    check_all("sprk_rest");
    tick_n(9);
    expect_val("restante", 1); expect_val("estado", 3);
    check_all("rest_last");
    tick_n(1);
    clks(4);
    expect_val("estado", 2); expect_val("zona", 4'b0100); expect_val("restante", 120);
    check_all("sprk_again");

    // Tank empties mid-run
    set_tank(3'b000);
    clks(3);
    expect_val("estado", 3); expect_val("restante", 10); expect_val("Alarme", 1);
    expect_val("Ve", 1); expect_val("Bs", 0);
    check_all("tank_empty");
    tick_n(10);
    clks(5);
    expect_val("estado", 0); expect_val("Ve", 1);
    check_all("empty_no_run");
    set_tank(3'b011);
    clks(4);
    expect_val("Ve", 1); expect_val("Alarme", 0);
    check_all("refill_mid");
    set_tank(3'b111);
    clks(4);
    expect_val("Ve", 0);
    check_all("refill_full");

    // Sensor fault mid-run
    tick_n(1);
    clks(4);
    expect_val("estado", 2); expect_val("zona", 4'b0100);
    check_all("fault_pre");
    set_tank(3'b101);
    clks(3);
    expect_val("estado", 4); expect_val("Erro", 1); expect_val("Bs", 0);
    expect_val("zona", 0); expect_val("Ve", 0); expect_val("Alarme", 1); expect_val("restante", 0);
    check_all("fault");
    set_tank(3'b111);
    clks(3);
    expect_val("estado", 4);
    check_all("fault_hold");
    tick_n(1);
    expect_val("estado", 0); expect_val("Erro", 0);
    check_all("fault_exit");

    // Async reset mid-run
    tick_n(1);
    clks(4);
    expect_val("estado", 2);
    check_all("reset_pre");
    @(negedge clk) reset_n = 1'b0;
    #1;
    expect_val("estado", 0); expect_val("Bs", 0); expect_val("Vs", 0); expect_val("zona", 0);
    expect_val("restante", 0); expect_val("Erro", 0); expect_val("idx", 0); expect_val("Ve", 0);
`ifdef BCD_TIME_EN
    expect_val("min_u", 0); expect_val("seg_u", 0);
`endif
    check_all("async_reset");
    clks(1);
    reset_n = 1'b1;
    clks(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
